// File: rtl/demux_stripe.sv
// Round-robin word striper: stages consecutive valid words into LANES lanes and emits them as one group.
// Optional build macro DEMUX_ZERO_IDLE_EN forces data_out lanes with valid_out=0 to zero in every cycle.
module demux_stripe #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic                      valid_in,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      flush,
  output logic [LANES*DATA_W-1:0]   data_out,
  output logic [LANES-1:0]          valid_out,
  output logic [$clog2(LANES)-1:0]  lane_ptr
);

  localparam int PTR_W = $clog2(LANES);
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);

  logic [LANES-1:0][DATA_W-1:0] stage_q, stage_d;
  logic [LANES-1:0]             mask_q, mask_d;
  logic [PTR_W-1:0]             ptr_q, ptr_d;
  logic [LANES*DATA_W-1:0]      dout_q, dout_d;
  logic [LANES-1:0]             vout_q, vout_d;
  logic [LANES-1:0]             mask_w;
  logic                         emit;

  always_comb begin
    stage_d = stage_q;
    mask_w  = mask_q;
    if (valid_in) begin
      stage_d[ptr_q] = data_in;
      mask_w[ptr_q]  = 1'b1;
    end

    // A flush that coincides with the final word folds into the same single emission.
    emit = (valid_in && (ptr_q == LAST_LANE)) ||
           (flush && ((mask_q != '0) || valid_in));

    mask_d = mask_w;
    ptr_d  = ptr_q;
    vout_d = '0;
`ifdef DEMUX_ZERO_IDLE_EN
    dout_d = '0;
`else
    dout_d = dout_q;
`endif

    if (emit) begin
      mask_d = '0;
      ptr_d  = '0;
      vout_d = mask_w;
      // Only lanes filled in this group are driven; the rest never expose stale staging data.
      for (int i = 0; i < LANES; i++) begin
        if (mask_w[i]) begin
          dout_d[i*DATA_W +: DATA_W] = stage_d[i];
        end
      end
    end else if (valid_in) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      stage_q <= '0;
      mask_q  <= '0;
      ptr_q   <= '0;
      dout_q  <= '0;
      vout_q  <= '0;
    end else begin
      stage_q <= stage_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
    end
  end

  assign data_out  = dout_q;
  assign valid_out = vout_q;
  assign lane_ptr  = ptr_q;

endmodule

// File: tb/tb_demux_stripe.sv
// Bench for demux_stripe (LANES=4, DATA_W=8): vector table, directed sequences, random run vs group-queue model.
module tb_demux_stripe;
  localparam int DW = 8;
  localparam int LN = 4;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          valid_in = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [LN*DW-1:0] data_out;
  logic [LN-1:0]    valid_out;
  logic [1:0]       lane_ptr;

  demux_stripe #(.DATA_W(DW), .LANES(LN)) dut (
    .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .flush(flush), .data_out(data_out), .valid_out(valid_out), .lane_ptr(lane_ptr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        rst_n;
    logic        v;
    logic [7:0]  d;
    logic        f;
    logic [3:0]  vo;
    logic [31:0] dout;
    logic [1:0]  ptr;
  } vec_t;
  vec_t tbl[$];

  // Model: words of the open group in arrival order, plus the last value shown on each lane.
  logic [7:0]  grp[$];
  logic [7:0]  last_lane[4];
  logic [3:0]  m_vo;
  logic [31:0] m_do;
  logic [1:0]  m_ptr;

  function automatic logic [31:0] zero_idle(input logic [31:0] d, input logic [3:0] vo);
    logic [31:0] r;
    r = d;
    for (int i = 0; i < 4; i++) if (!vo[i]) r[i*8 +: 8] = 8'h00;
    return r;
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] d, input logic [3:0] vo);
`ifdef DEMUX_ZERO_IDLE_EN
    return zero_idle(d, vo);
`else
    return d;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic rst_n, input logic v, input logic [7:0] d, input logic f);
    reset_L  = rst_n;
    valid_in = v;
    data_in  = d;
    flush    = f;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input logic rst_n, input logic v, input logic [7:0] d, input logic f);
    int n;
    if (!rst_n) begin
      grp.delete();
      for (int i = 0; i < 4; i++) last_lane[i] = 8'h00;
      m_vo = 4'b0000;
    end else begin
      if (v) grp.push_back(d);
      n = grp.size();
      if (n == 4 || (f && n > 0)) begin
        m_vo = 4'((1 << n) - 1);
        for (int i = 0; i < n; i++) last_lane[i] = grp[i];
        grp.delete();
      end else begin
        m_vo = 4'b0000;
      end
    end
    m_ptr = 2'(grp.size());
    m_do  = {last_lane[3], last_lane[2], last_lane[1], last_lane[0]};
    m_do  = exp_data(m_do, m_vo);
  endtask

  task automatic run(input logic rst_n, input logic v, input logic [7:0] d, input logic f);
    apply(rst_n, v, d, f);
    model_step(rst_n, v, d, f);
    chk("model_valid_out", 32'(valid_out), 32'(m_vo));
    chk("model_data_out", data_out, m_do);
    chk("model_lane_ptr", 32'(lane_ptr), 32'(m_ptr));
  endtask

  task automatic addv(input logic r, input logic v, input logic [7:0] d, input logic f,
                      input logic [3:0] vo, input logic [31:0] dout, input logic [1:0] ptr);
    vec_t e;
    e.rst_n = r; e.v = v; e.d = d; e.f = f; e.vo = vo; e.dout = dout; e.ptr = ptr;
    tbl.push_back(e);
  endtask

  initial begin
    // rst, v, d, f  ->  valid_out, data_out (unmasked form), lane_ptr
    addv(0, 1, 8'h99, 1, 4'b0000, 32'h00000000, 2'd0);  // reset overrides valid/flush
    addv(1, 1, 8'h11, 0, 4'b0000, 32'h00000000, 2'd1);
    addv(1, 1, 8'h22, 0, 4'b0000, 32'h00000000, 2'd2);
    addv(1, 1, 8'h33, 0, 4'b0000, 32'h00000000, 2'd3);
    addv(1, 1, 8'h44, 0, 4'b1111, 32'h44332211, 2'd0);
    addv(1, 0, 8'h00, 0, 4'b0000, 32'h44332211, 2'd0);
    addv(1, 1, 8'hAA, 0, 4'b0000, 32'h44332211, 2'd1);
    addv(1, 1, 8'hBB, 0, 4'b0000, 32'h44332211, 2'd2);
    addv(1, 0, 8'h00, 1, 4'b0011, 32'h4433BBAA, 2'd0);
    addv(1, 0, 8'h00, 1, 4'b0000, 32'h4433BBAA, 2'd0);  // flush on empty: no effect
    addv(1, 1, 8'h10, 0, 4'b0000, 32'h4433BBAA, 2'd1);
    addv(1, 1, 8'h20, 0, 4'b0000, 32'h4433BBAA, 2'd2);
    addv(1, 1, 8'h30, 0, 4'b0000, 32'h4433BBAA, 2'd3);
    addv(1, 1, 8'h40, 1, 4'b1111, 32'h40302010, 2'd0);  // flush + last word: one emission
    addv(1, 0, 8'h00, 0, 4'b0000, 32'h40302010, 2'd0);
    addv(1, 1, 8'h77, 1, 4'b0001, 32'h40302077, 2'd0);  // flush with empty mask but valid word
    addv(1, 0, 8'h00, 0, 4'b0000, 32'h40302077, 2'd0);

    foreach (tbl[k]) begin
      apply(tbl[k].rst_n, tbl[k].v, tbl[k].d, tbl[k].f);
      chk($sformatf("tbl%0d_valid_out", k), 32'(valid_out), 32'(tbl[k].vo));
      chk($sformatf("tbl%0d_data_out", k), data_out, exp_data(tbl[k].dout, tbl[k].vo));
      chk($sformatf("tbl%0d_lane_ptr", k), 32'(lane_ptr), 32'(tbl[k].ptr));
    end

    // Eight back-to-back words: two full groups four cycles apart.
    run(0, 0, 8'h00, 0);
    for (int w = 1; w <= 8; w++) begin
      run(1, 1, 8'(w), 0);
      if (w == 4) chk("b2b_group1", data_out, 32'h04030201);
    end
    chk("b2b_group2", data_out, 32'h08070605);
    chk("b2b_ptr_end", 32'(lane_ptr), 32'd0);
    run(1, 0, 8'h00, 0);

    // Gaps between valid words do not disturb the group.
    run(1, 1, 8'hA1, 0);
    run(1, 0, 8'h00, 0);
    run(1, 0, 8'h00, 0);
    run(1, 1, 8'hA2, 0);
    run(1, 0, 8'h00, 0);
    run(1, 1, 8'hA3, 0);
    chk("gap_no_early", 32'(valid_out), 32'd0);
    run(1, 1, 8'hA4, 0);
    chk("gap_group", data_out, 32'hA4A3A2A1);
    chk("gap_valid", 32'(valid_out), 32'hF);

    // Reset during a partial group discards it.
    run(1, 1, 8'h5A, 0);
    run(1, 1, 8'h5B, 0);
    run(0, 1, 8'hEE, 0);
    chk("rst_no_emit", 32'(valid_out), 32'd0);
    for (int w = 1; w <= 4; w++) begin
      run(1, 1, 8'(w), 0);
      if (w < 4) chk("rst_no_emit_refill", 32'(valid_out), 32'd0);
    end
    chk("rst_group", data_out, 32'h04030201);

    // Randomized traffic against the group-queue model.
    for (int c = 0; c < 400; c++) begin
      run(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
          8'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_stripe.md
DEMUX_STRIPE -- requirements
Module: demux_stripe

Interface
REQ-001 Parameter DATA_W, default 8, width of one input word and one output lane.
REQ-002 Parameter LANES, default 4, number of output lanes; legal values 2, 4, 8.
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port reset_L  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 Port valid_in  input  1  data_in carries a word this cycle.
REQ-006 Port data_in  input  DATA_W  input word.
REQ-007 Port flush  input  1  emit the partially filled group.
REQ-008 Port data_out  output  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W]; registered.
REQ-009 Port valid_out  output  LANES  bit i qualifies lane i; registered.
REQ-010 Port lane_ptr  output  clog2(LANES)  lane that receives the next accepted word.

Function
REQ-011 Block SHALL stripe consecutive valid words round-robin across lanes 0..LANES-1, then present them together as one group.
REQ-012 Cycle with valid_in=1: data_in SHALL be written to staging lane lane_ptr, its fill-mask bit set, lane_ptr incremented.
REQ-013 lane_ptr SHALL wrap from LANES-1 to 0.
REQ-014 Cycle with valid_in=0: lane_ptr, staging and fill mask SHALL hold.
REQ-015 Word accepted into lane LANES-1: the next cycle SHALL show all staged lanes on data_out with valid_out all ones, for exactly one cycle.
REQ-016 Latency from the last word of a group to valid_out SHALL be 1 cycle.
REQ-017 Back-to-back groups at one word per cycle SHALL be sustained with no bubble or loss; the fill mask clears in the cycle the group is emitted.
REQ-018 flush=1 with a non-empty fill mask, or with valid_in=1, SHALL emit the next cycle with valid_out equal to the fill mask, including any word accepted that cycle. lane_ptr SHALL return to 0 and the mask SHALL clear.
REQ-019 flush=1 with an empty mask and valid_in=0 SHALL have no effect; valid_out stays 0.
REQ-020 flush=1 together with valid_in=1 at lane_ptr=LANES-1 SHALL produce exactly one full emission, not two.
REQ-021 valid_out SHALL be all zeros in every cycle with no emission.
REQ-022 Staging lanes not written in the current group SHALL NOT carry stale data into an emission; their valid_out bit is 0.

Reset
REQ-023 reset_L=0 at posedge clk SHALL clear lane_ptr, fill mask, staging, data_out and valid_out to 0.
REQ-024 Reset SHALL override valid_in and flush in the same cycle.
REQ-025 Reset during a partial group SHALL discard that group with no emission.
REQ-026 The first cycle after reset_L returns to 1 SHALL accept a word into lane 0.

Configuration
REQ-027 Macro DEMUX_ZERO_IDLE_EN: when defined, data_out lanes whose valid_out bit is 0 SHALL be driven to 0 in every cycle.
REQ-028 Without DEMUX_ZERO_IDLE_EN, data_out SHALL change only on emission. Unqualified lanes keep their last emitted value (lower toggle power).

Verification
REQ-029 LANES=4, DATA_W=8: valid words 0x11,0x22,0x33,0x44 on consecutive cycles -> the next cycle shows data_out=0x44332211 and valid_out=4'b1111 for one cycle.
REQ-030 Eight consecutive words 0x01..0x08 -> two emissions, 0x04030201 and 0x08070605, four cycles apart; lane_ptr ends at 0.
REQ-031 Words 0xAA,0xBB, then flush with valid_in=0 -> valid_out=4'b0011 and lanes 1:0 = 0xBB,0xAA. With DEMUX_ZERO_IDLE_EN, lanes 3:2 = 0x00.
REQ-032 valid_in gaps (0xA1, idle, idle, 0xA2, idle, 0xA3, 0xA4) -> one emission 0xA4A3A2A1, one cycle after 0xA4.
REQ-033 Words 0x5A,0x5B, then reset_L=0 for 1 cycle, then 0x01..0x04 -> no emission of 0x5A/0x5B; the single emission is 0x04030201.
REQ-034 flush=1 with valid_in=1 at lane_ptr=3 after 0x10,0x20,0x30 plus 0x40 -> exactly one emission, 0x40302010 with valid_out=4'b1111; the following cycle has valid_out=0.
